// File: rtl/spi_ctrl_pkg.sv
// Shared encodings for the SPI peripheral arbiter: FSM states, status-word
// bit positions and the master's divider codes.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ARM     = 3'd2,
    ACK     = 3'd3,
    RUN     = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam int OP_BIT  = 0;
  localparam int FBO_BIT = 1;
  localparam int DIV_LSB = 2;
  localparam int EN_BIT  = 5;

  localparam logic [2:0] DIV_1  = 3'b000;
  localparam logic [2:0] DIV_2  = 3'b001;
  localparam logic [2:0] DIV_4  = 3'b010;
  localparam logic [2:0] DIV_8  = 3'b011;
  localparam logic [2:0] DIV_16 = 3'b100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping to index 0. The caller owns and advances ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Upper pass covers [ptr, NUM_REQ-1]; the lower pass only fires when that
  // range is empty, which yields the wrapped winner below ptr.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        valid  = 1'b1;
        idx    = IDX_W'(i);
        gnt[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        valid  = 1'b1;
        idx    = IDX_W'(i);
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_periph_arbiter.sv
// Shares one spi_perifericos master among NUM_REQ requesters: round-robin
// grant, one 1-byte-out / 2-byte-in transaction per grant, stall watchdog.
//
// state   | meaning
// IDLE    | no owner; pick next requester from ptr
// GRANT   | owner latched, data/divider/fbo presented to master
// ARM     | raise operation bit
// ACK     | wait for master done flag to drop (send started)
// RUN     | wait for master done flag to rise, capture response
// RELEASE | operation low, done/err pulse, advance ptr
module spi_periph_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      spi_clk_i,
  input  logic                      spi_rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*4-1:0]      req_cfg_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [2*DATA_WIDTH-1:0]   rsp_data_o,
  output logic [5:0]                spi_statusreg_o,
  output logic [DATA_WIDTH-1:0]     spi_data_o,
  input  logic                      spi_doneflag_i,
  input  logic [2*DATA_WIDTH-1:0]   spi_rsp_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       idx;
  logic [WD_W-1:0]        wd;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [3:0]             sel_cfg;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_i),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_data = '0;
    sel_cfg  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_cfg  = req_cfg_i[k*4 +: 4];
      end
    end
  end

  // The latched byte and config live directly in the output registers, so
  // they stay frozen for the whole grant regardless of requester activity.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state           <= IDLE;
      ptr             <= '0;
      idx             <= '0;
      wd              <= '0;
      grant_o         <= '0;
      done_o          <= '0;
      err_o           <= '0;
      rsp_data_o      <= '0;
      spi_statusreg_o <= '0;
      spi_data_o      <= '0;
    end else begin
      done_o                  <= '0;
      err_o                   <= '0;
      spi_statusreg_o[EN_BIT] <= 1'b1;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            idx                            <= arb_idx;
            grant_o                        <= arb_gnt;
            spi_data_o                     <= sel_data;
            spi_statusreg_o[DIV_LSB +: 3]  <= sel_cfg[3:1];
            spi_statusreg_o[FBO_BIT]       <= sel_cfg[0];
            state                          <= GRANT;
          end
        end
        GRANT: state <= ARM;
        ARM: begin
          spi_statusreg_o[OP_BIT] <= 1'b1;
          wd                      <= WD_LOAD;
          state                   <= ACK;
        end
        ACK: begin
          if (!spi_doneflag_i) begin
            wd    <= WD_LOAD;
            state <= RUN;
          end else if (wd == '0) begin
            spi_statusreg_o[OP_BIT] <= 1'b0;
            err_o                   <= grant_o;
            grant_o                 <= '0;
            state                   <= RELEASE;
          end else begin
            wd <= wd - 1'b1;
          end
        end
        RUN: begin
          if (spi_doneflag_i) begin
            rsp_data_o              <= spi_rsp_i;
            spi_statusreg_o[OP_BIT] <= 1'b0;
            done_o                  <= grant_o;
            grant_o                 <= '0;
            state                   <= RELEASE;
          end else if (wd == '0) begin
            spi_statusreg_o[OP_BIT] <= 1'b0;
            err_o                   <= grant_o;
            grant_o                 <= '0;
            state                   <= RELEASE;
          end else begin
            wd <= wd - 1'b1;
          end
        end
        RELEASE: begin
          ptr   <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_periph_arbiter.sv
// Scoreboard bench for spi_periph_arbiter with a behavioural SPI master that
// answers each byte b with {b ^ 8'h99, ~b}.
module tb_spi_periph_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 16;

  typedef struct {
    logic [NR-1:0] owner;
    bit            is_err;
    logic [15:0]   rsp;
    logic [7:0]    mosi;
    logic [5:0]    stat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR*4-1:0]   req_cfg_i;
  logic [NR-1:0]     grant_o, done_o, err_o;
  logic [2*DW-1:0]   rsp_data_o;
  logic [5:0]        spi_statusreg_o;
  logic [DW-1:0]     spi_data_o;
  logic              spi_doneflag_i;
  logic [2*DW-1:0]   spi_rsp_i;

  logic [7:0]  data_k [NR];
  logic [3:0]  cfg_k  [NR];
  exp_t        sb[$];
  logic [15:0] last_rsp;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit   stall = 0;
  int   run_len = 3;
  bit   active = 0;
  int   cnt = 0;
  int   rise_t = 0;
  logic [7:0] cap_mosi;

  logic [NR-1:0] prev_grant = '0;
  logic prev_op = 1'b0;
  int   op_t = 0;
  int   low_run = 0;
  bit   seen_txn = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_periph_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .spi_clk_i       (clk),
    .spi_rst_i       (rst),
    .req_i           (req_i),
    .req_data_i      (req_data_i),
    .req_cfg_i       (req_cfg_i),
    .grant_o         (grant_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .rsp_data_o      (rsp_data_o),
    .spi_statusreg_o (spi_statusreg_o),
    .spi_data_o      (spi_data_o),
    .spi_doneflag_i  (spi_doneflag_i),
    .spi_rsp_i       (spi_rsp_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [15:0] slave_rsp(input logic [7:0] b);
    return {b ^ 8'h99, ~b};
  endfunction

  task automatic drive_bus();
    for (int k = 0; k < NR; k++) begin
      req_data_i[k*DW +: DW] = data_k[k];
      req_cfg_i[k*4 +: 4]    = cfg_k[k];
    end
  endtask

  task automatic push_txn(input int k, input bit is_err);
    exp_t e;
    e.owner  = NR'(1) << k;
    e.is_err = is_err;
    e.mosi   = data_k[k];
    e.stat   = {1'b1, cfg_k[k], 1'b1};
    if (!is_err) last_rsp = slave_rsp(data_k[k]);
    e.rsp    = last_rsp;
    sb.push_back(e);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if ((|done_o) || (|err_o)) got++;
    end
    if (got < n) chk("wait_pulses", got, n);
  endtask

  task automatic wait_run(input int budget);
    int t = 0;
    while (spi_doneflag_i && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (spi_doneflag_i) chk("wait_run", 0, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_grant"}, grant_o, 0);
    chk({pfx, "_done"}, done_o, 0);
    chk({pfx, "_err"}, err_o, 0);
    chk({pfx, "_rsp"}, rsp_data_o, 0);
    chk({pfx, "_stat"}, spi_statusreg_o, 0);
    chk({pfx, "_mosi"}, spi_data_o, 0);
  endtask

  // Behavioural master: drops its done flag 2 cycles into a transfer,
  // raises it with the response run_len cycles later; never drops when stalled.
  initial begin
    spi_doneflag_i = 1'b1;
    spi_rsp_i      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
        spi_doneflag_i = 1'b1;
      end else if (spi_statusreg_o[0] && !active) begin
        active   = 1;
        cnt      = 0;
        cap_mosi = spi_data_o;
      end else if (active) begin
        if (!spi_statusreg_o[0]) begin
          active = 0;
          spi_doneflag_i = 1'b1;
        end else if (!stall) begin
          cnt++;
          if (cnt == 2) spi_doneflag_i = 1'b0;
          if (cnt == 2 + run_len) begin
            spi_rsp_i      = slave_rsp(cap_mosi);
            spi_doneflag_i = 1'b1;
            rise_t         = cyc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (grant_o != '0 && prev_grant == '0) begin
        if (sb.size() == 0) chk("grant_unexpected", grant_o, 0);
        else chk("grant_owner", grant_o, sb[0].owner);
      end
      if (spi_statusreg_o[0] && !prev_op) begin
        op_t = cyc;
        if (seen_txn) chk("op_gap_ge2", low_run >= 2, 1);
        seen_txn = 1;
        if (sb.size() != 0) chk("stat_at_ack", spi_statusreg_o, sb[0].stat);
      end
      if ((|done_o) || (|err_o)) begin
        if (sb.size() == 0) chk("pulse_unexpected", {done_o, err_o}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_vec", done_o, e.is_err ? '0 : e.owner);
          chk("err_vec", err_o, e.is_err ? e.owner : '0);
          chk("rsp_data", rsp_data_o, e.rsp);
          chk("mosi_frozen", spi_data_o, e.mosi);
          chk("cfg_frozen", spi_statusreg_o[5:1], e.stat[5:1]);
          chk("op_low", spi_statusreg_o[0], 0);
          chk("grant_low", grant_o, 0);
          if (e.is_err) chk("timeout_latency", cyc - op_t, TO);
          else chk("done_latency", cyc - rise_t, 1);
        end
      end
    end
    low_run    = spi_statusreg_o[0] ? 0 : low_run + 1;
    prev_grant = grant_o;
    prev_op    = spi_statusreg_o[0];
  end

  initial begin
    rst = 1'b1;
    req_i = '0;
    last_rsp = '0;
    for (int k = 0; k < NR; k++) begin
      data_k[k] = '0;
      cfg_k[k]  = '0;
    end
    drive_bus();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Contention from ptr=0: order 0,1,3,0
    data_k[0] = 8'h11; cfg_k[0] = 4'b0000;
    data_k[1] = 8'h22; cfg_k[1] = 4'b1001;
    data_k[3] = 8'h44; cfg_k[3] = 4'b0110;
    drive_bus();
    push_txn(0, 0); push_txn(1, 0); push_txn(3, 0); push_txn(0, 0);
    @(negedge clk);
    req_i = 4'b1011;
    wait_pulses(4, 200);
    req_i = '0;

    // Single request, divider 3'b010 with fbo=1
    repeat (2) @(negedge clk);
    data_k[0] = 8'hA5; cfg_k[0] = 4'b0101;
    drive_bus();
    push_txn(0, 0);
    req_i = 4'b0001;
    wait_pulses(1, 60);
    req_i = '0;

    // Walk ptr to 3, then wrap: requests on 3 and 0
    repeat (2) @(negedge clk);
    data_k[2] = 8'h5E; cfg_k[2] = 4'b0011;
    drive_bus();
    push_txn(2, 0);
    req_i = 4'b0100;
    wait_pulses(1, 60);
    req_i = '0;
    @(negedge clk);
    data_k[3] = 8'hC3; cfg_k[3] = 4'b0100;
    data_k[0] = 8'h0F; cfg_k[0] = 4'b1000;
    drive_bus();
    push_txn(3, 0); push_txn(0, 0);
    req_i = 4'b1001;
    wait_pulses(2, 120);
    req_i = '0;

    // Stalled master: watchdog error, response unchanged
    repeat (2) @(negedge clk);
    stall = 1;
    data_k[1] = 8'h77; cfg_k[1] = 4'b0010;
    drive_bus();
    push_txn(1, 1);
    req_i = 4'b0010;
    wait_pulses(1, 60);
    req_i = '0;
    stall = 0;

    // Data/config change and request drop while in RUN
    repeat (2) @(negedge clk);
    run_len = 10;
    data_k[2] = 8'h96; cfg_k[2] = 4'b0111;
    drive_bus();
    push_txn(2, 0);
    req_i = 4'b0100;
    wait_run(40);
    repeat (2) @(negedge clk);
    data_k[2] = 8'h69; cfg_k[2] = 4'b1110;
    drive_bus();
    req_i = '0;
    wait_pulses(1, 60);

    // Reset during RUN, then fresh arbitration from ptr=0
    repeat (2) @(negedge clk);
    run_len = 20;
    data_k[3] = 8'hD2; cfg_k[3] = 4'b0001;
    data_k[0] = 8'h0F; cfg_k[0] = 4'b1000;
    drive_bus();
    push_txn(3, 0);
    req_i = 4'b1001;
    wait_run(40);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    sb.delete();
    last_rsp = '0;
    run_len = 3;
    push_txn(0, 0); push_txn(3, 0);
    rst = 1'b0;
    wait_pulses(2, 120);
    req_i = '0;

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
